fifo_flags: RTL and testbench

Parametrised synchronous FIFO, next generation of the team's single-clock `fifo`. It adds:
- simultaneous read and write in one cycle;
- an occupancy count, programmable almost-full/almost-empty flags and overflow/underflow error pulses;
- an output-valid qualifier.

It sits between a producer and a consumer in the same clock domain. It is the standard buffering element for the UVM testbenches and DUT wrappers in this codebase.

---
 rtl/fifo_flags.sv | 124 ++++++++++++
 tb/tb_fifo_flags.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, almost-full/empty flags, error pulses and an output-valid qualifier.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise reads are registered (1-cycle latency).
module fifo_flags #(
  parameter int AWIDTH    = 4,
  parameter int DWIDTH    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              read_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0]   FULL_CNT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_CNT   = (AWIDTH+1)'(AFULL_TH);
  localparam logic [AWIDTH:0]   AE_CNT   = (AWIDTH+1)'(AEMPTY_TH);
  localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

  // Thresholds must leave a gap, otherwise both flags could be high at once.
  if (AEMPTY_TH >= AFULL_TH) begin : g_bad_thresholds
    $error("fifo_flags: AEMPTY_TH (%0d) must be below AFULL_TH (%0d)", AEMPTY_TH, AFULL_TH);
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_range
    $error("fifo_flags: threshold out of range for DEPTH %0d", DEPTH);
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] rptr_q, rptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc      = write_en && !full;
    rd_acc      = read_en && !empty;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = write_en && full;
    underflow_d = read_en && empty;
    if (wr_acc) wptr_d = wptr_q + PTR_ONE;
    if (rd_acc) rptr_d = rptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; reset still blocks a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr_q] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out   = mem[rptr_q];
  assign data_valid = !empty;
`else
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = rd_acc;
    if (rd_acc) data_out_d = mem[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench for fifo_flags: vector table, reference-queue scoreboard and corner-case sequences.
module tb_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic [3:0] data_in;
  logic       read_en;
  logic [3:0] data_out;
  logic       data_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  fifo_flags #(.AWIDTH(4), .DWIDTH(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] mq[$];     // reference contents
  logic [3:0] expq[$];   // expected read data, in order
  logic [3:0] last_dout;

  typedef struct {
    logic       we;
    logic [3:0] din;
    logic       re;
    int         cnt;
    logic       ae;
    logic       dv;
    logic [3:0] dout;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic we, input logic [3:0] d, input logic re);
    int sz;
    bit ra, ovf, unf;
    write_en = we;
    data_in  = d;
    read_en  = re;
    sz  = mq.size();
    ra  = re && (sz > 0);
    ovf = we && (sz == 16);
    unf = re && (sz == 0);
    if (ra) expq.push_back(mq.pop_front());
    if (we && sz < 16) mq.push_back(d);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    sz = mq.size();
    chk("count", count, sz);
    chk("full", full, sz == 16);
    chk("empty", empty, sz == 0);
    chk("almost_full", almost_full, sz >= 12);
    chk("almost_empty", almost_empty, sz <= 4);
    chk("overflow", overflow, ovf);
    chk("underflow", underflow, unf);
`ifdef FIFO_FWFT_EN
    chk("data_valid", data_valid, sz > 0);
    if (sz > 0) chk("fwft_data_out", data_out, mq[0]);
    expq.delete();
`else
    chk("data_valid", data_valid, ra);
    if (data_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_read_data", 1, 0);
      end else begin
        last_dout = expq.pop_front();
        chk("data_out", data_out, last_dout);
      end
    end else begin
      chk("data_out_hold", data_out, last_dout);
    end
`endif
  endtask

  task automatic clear_model();
    mq.delete();
    expq.delete();
    last_dout = 4'h0;
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = 4'h0;
    clear_model();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_data_valid", data_valid, 0);
`ifndef FIFO_FWFT_EN
    chk("rst_data_out", data_out, 0);
`endif

    // Flag thresholds around count 4/5, then a first read and a mixed cycle
    tbl[0] = '{1'b1, 4'h1, 1'b0, 1, 1'b1, 1'b0, 4'h0};
    tbl[1] = '{1'b1, 4'h2, 1'b0, 2, 1'b1, 1'b0, 4'h0};
    tbl[2] = '{1'b1, 4'h3, 1'b0, 3, 1'b1, 1'b0, 4'h0};
    tbl[3] = '{1'b1, 4'h4, 1'b0, 4, 1'b1, 1'b0, 4'h0};
    tbl[4] = '{1'b1, 4'h5, 1'b0, 5, 1'b0, 1'b0, 4'h0};
    tbl[5] = '{1'b0, 4'h0, 1'b1, 4, 1'b1, 1'b1, 4'h1};
    tbl[6] = '{1'b1, 4'h6, 1'b1, 4, 1'b1, 1'b1, 4'h2};
    tbl[7] = '{1'b0, 4'h0, 1'b0, 4, 1'b1, 1'b0, 4'h2};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].din, tbl[i].re);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_almost_empty", i), almost_empty, tbl[i].ae);
`ifndef FIFO_FWFT_EN
      chk($sformatf("tbl%0d_data_valid", i), data_valid, tbl[i].dv);
      chk($sformatf("tbl%0d_data_out", i), data_out, tbl[i].dout);
`endif
    end
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1);

    // Fill, overflow, read-while-full, drain
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'(i), 1'b0);
      chk("fill_almost_full", almost_full, i + 1 >= 12);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    step(1'b1, 4'h7, 1'b0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    step(1'b0, 4'h0, 1'b0);
    chk("ovf_cleared", overflow, 0);
    step(1'b1, 4'h9, 1'b1);
    chk("full_rw_count", count, 15);
    chk("full_rw_overflow", overflow, 1);
    for (int i = 0; i < 15; i++) step(1'b0, 4'h0, 1'b1);
    chk("drain_empty", empty, 1);

    // Underflow, repeated and then cleared
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);
    chk("unf_cleared", underflow, 0);

    // Sustained read+write at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)), 1'b1);
      chk("rw_count", count, 5);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1);

    // Reset mid-stream at count 9 with both requests high
    for (int i = 0; i < 9; i++) step(1'b1, 4'(i + 1), 1'b0);
    rst = 1'b1; write_en = 1'b1; read_en = 1'b1; data_in = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
    clear_model();
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_data_valid", data_valid, 0);
    step(1'b1, 4'hC, 1'b0);
    step(1'b1, 4'hB, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);

`ifdef FIFO_FWFT_EN
    // Fall-through: written word visible without read_en, pop shows next word
    step(1'b1, 4'hA, 1'b0);
    chk("fwft_first", data_out, 4'hA);
    step(1'b1, 4'hB, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    chk("fwft_next", data_out, 4'hB);
    step(1'b0, 4'h0, 1'b1);
`endif

    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
